// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge: OBI (req/gnt/rvalid/rready) to Wishbone classic master bridge.
// One Wishbone transfer in flight at a time; responses are queued in a small
// FIFO so the core can stall response acceptance without losing data.
// Optional bus watchdog: define OBI_WB_TIMEOUT_EN to abort transfers that
// receive no ack/err within TIMEOUT_CYCLES cycles.
module obi_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RESP_DEPTH     = 2,
    parameter int WRITE_RVALID   = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    // Reject configurations the datapath cannot represent.
    if ((DATA_WIDTH % 8) != 0 || RESP_DEPTH < 1 ||
        (RESP_DEPTH & (RESP_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("obi_wb_bridge: invalid parameter set");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_e;

    state_e                  state_q;
    logic                    wb_cyc_q;
    logic                    wb_we_q;
    logic [SEL_W-1:0]        wb_sel_q;
    logic [ADDR_WIDTH-1:0]   wb_addr_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;

    logic [DATA_WIDTH-1:0]   mem_data_q [RESP_DEPTH];
    logic                    mem_err_q  [RESP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    done_s;
    logic                    push_s;
    logic                    pop_s;
    logic [DATA_WIDTH-1:0]   push_data_s;
    logic                    push_err_s;
    logic                    timeout_s;

    // Pointer advance with explicit wrap so non-full index ranges stay legal.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RESP_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Grant only from IDLE and only while a FIFO slot is guaranteed free.
    assign obi_gnt_o    = (state_q == ST_IDLE) && obi_req_i && (count_q != CNT_W'(RESP_DEPTH));
    assign obi_rvalid_o = (count_q != {CNT_W{1'b0}});
    assign pop_s        = obi_rvalid_o && obi_rready_i;
    assign obi_rdata_o  = obi_rvalid_o ? mem_data_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
    assign obi_err_o    = obi_rvalid_o ? mem_err_q[rd_ptr_q] : 1'b0;

    assign wb_cyc_o  = wb_cyc_q;
    assign wb_stb_o  = wb_cyc_q;
    assign wb_we_o   = wb_we_q;
    assign wb_sel_o  = wb_sel_q;
    assign wb_addr_o = wb_addr_q;
    assign wb_data_o = wb_data_q;

`ifdef OBI_WB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;

    // Watchdog: restarts at each grant, counts every cycle spent waiting in BUS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= {WD_W{1'b0}};
        end else if (obi_gnt_o) begin
            wdog_q <= {WD_W{1'b0}};
        end else if ((state_q == ST_BUS) && !done_s) begin
            wdog_q <= wdog_q + WD_W'(1);
        end else begin
            wdog_q <= wdog_q;
        end
    end

    assign timeout_s = (state_q == ST_BUS) && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Transfer completion and response formation; error beats ack, timeout is last resort.
    always_comb begin
        done_s      = 1'b0;
        push_s      = 1'b0;
        push_data_s = {DATA_WIDTH{1'b0}};
        push_err_s  = 1'b0;
        if (state_q == ST_BUS) begin
            if (wb_err_i) begin
                done_s     = 1'b1;
                push_err_s = 1'b1;
                push_s     = !wb_we_q || (WRITE_RVALID != 0);
            end else if (wb_ack_i) begin
                done_s      = 1'b1;
                push_data_s = wb_we_q ? {DATA_WIDTH{1'b0}} : wb_data_i;
                push_s      = !wb_we_q || (WRITE_RVALID != 0);
            end else if (timeout_s) begin
                done_s     = 1'b1;
                push_err_s = 1'b1;
                push_s     = 1'b1;
            end else begin
                done_s = 1'b0;
            end
        end else begin
            done_s = 1'b0;
        end
    end

    // Request FSM: captures the OBI request on grant and holds the Wishbone cycle until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wb_cyc_q  <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_sel_q  <= {SEL_W{1'b0}};
            wb_addr_q <= {ADDR_WIDTH{1'b0}};
            wb_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (obi_gnt_o) begin
                        state_q   <= ST_BUS;
                        wb_cyc_q  <= 1'b1;
                        wb_we_q   <= obi_we_i;
                        wb_sel_q  <= obi_be_i;
                        wb_addr_q <= obi_addr_i;
                        wb_data_q <= obi_we_i ? obi_wdata_i : {DATA_WIDTH{1'b0}};
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (done_s) begin
                        state_q   <= ST_IDLE;
                        wb_cyc_q  <= 1'b0;
                        wb_we_q   <= 1'b0;
                        wb_sel_q  <= {SEL_W{1'b0}};
                        wb_addr_q <= {ADDR_WIDTH{1'b0}};
                        wb_data_q <= {DATA_WIDTH{1'b0}};
                    end else begin
                        state_q <= ST_BUS;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    wb_cyc_q <= 1'b0;
                end
            endcase
        end
    end

    // Response FIFO: registered storage, head visible the cycle after the push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_data_q[i] <= {DATA_WIDTH{1'b0}};
                mem_err_q[i]  <= 1'b0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_data_q[wr_ptr_q] <= push_data_s;
                mem_err_q[wr_ptr_q]  <= push_err_s;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Scoreboard bench for obi_wb_bridge: a driver issues OBI requests and pushes
// the expected response into a queue, a Wishbone slave model plays out a
// per-transaction plan, and a monitor pops/compares each accepted response.
module tb_obi_wb_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int WRV = 1;
    localparam int TO  = 8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;
        int          kind;   // 0 ack, 1 err, 2 ack+err, 3 silent
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          obi_req_i, obi_gnt_o, obi_we_i, obi_rvalid_o, obi_rready_i, obi_err_o;
    logic [31:0]   obi_addr_i, obi_wdata_i, obi_rdata_o;
    logic [3:0]    obi_be_i, wb_sel_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
    logic [31:0]   wb_addr_o, wb_data_o, wb_data_i;

    txn_t  plan_q[$];
    resp_t exp_q[$];
    int    pass_cnt = 0;
    int    chk_cnt  = 0;
    int    rr_mode  = 1;   // 0 hold rready low, 1 high, 2 random
    bit    spur_en  = 1'b0;
    int    last_cyc_len = 0;
    int    cyc_run = 0;

    obi_wb_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(2),
        .WRITE_RVALID(WRV), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
        .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o), .obi_rready_i(obi_rready_i),
        .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: what the core must see for a transaction, from the bridge rules.
    task automatic push_txn(input txn_t t, input bit lost);
        resp_t r;
        plan_q.push_back(t);
        if (!lost) begin
            if (t.kind == 3) begin
                r.data = 32'h0; r.err = 1'b1; exp_q.push_back(r);
            end else if (t.we && WRV == 0) begin
                // silent write completion
            end else if (t.kind != 0) begin
                r.data = 32'h0; r.err = 1'b1; exp_q.push_back(r);
            end else begin
                r.data = t.we ? 32'h0 : t.rdata; r.err = 1'b0; exp_q.push_back(r);
            end
        end
    endtask

    // Called at negedge+1; returns at negedge+1 after the grant edge.
    task automatic do_req(input txn_t t);
        int n = 0;
        obi_req_i = 1'b1; obi_we_i = t.we; obi_addr_i = t.addr;
        obi_be_i = t.be; obi_wdata_i = t.wdata;
        #1;
        while (!obi_gnt_o && n < 200) begin
            @(negedge clk); #2; n++;
        end
        if (!obi_gnt_o) begin
            chk_cnt++;
            $display("FAIL grant_timeout: no gnt after %0d cycles, required gnt=1", n);
        end
        @(negedge clk); #1;
        obi_req_i = 1'b0;
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wd, input int waits, input int kind,
                                input logic [31:0] rd);
        txn_t t;
        t.we = we; t.addr = addr; t.be = be; t.wdata = wd;
        t.waits = waits; t.kind = kind; t.rdata = rd;
        return t;
    endfunction

    // Length of the most recent contiguous cyc burst.
    always @(negedge clk) begin
        if (!rst_n) cyc_run = 0;
        else if (wb_cyc_o) cyc_run++;
        else if (cyc_run > 0) begin last_cyc_len = cyc_run; cyc_run = 0; end
    end

    // Wishbone slave model executing the plan queue.
    txn_t cur;
    bit   busy = 1'b0;
    int   cnt = 0;
    always @(negedge clk) begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = $urandom;
        if (!rst_n) begin
            busy = 1'b0;
        end else begin
            if (busy && !wb_cyc_o) begin
                busy = 1'b0;
                if (cur.kind == 3) wb_ack_i = 1'b1;   // late ack after abort
            end else if (wb_cyc_o && !busy) begin
                if (plan_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unplanned_cyc: cyc=1 with no planned transfer, required cyc=0");
                end else begin
                    cur = plan_q.pop_front(); busy = 1'b1; cnt = cur.waits;
                end
            end
            if (busy && wb_cyc_o) begin
                chk("wb_fields", 128'({wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o}),
                    128'({1'b1, cur.we, cur.be, cur.addr, cur.we ? cur.wdata : 32'h0}));
                if (cur.kind != 3) begin
                    if (cnt == 0) begin
                        case (cur.kind)
                            0: begin wb_ack_i = 1'b1; if (!cur.we) wb_data_i = cur.rdata; end
                            1: wb_err_i = 1'b1;
                            default: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
                        endcase
                        busy = 1'b0;
                    end else cnt--;
                end
            end else if (!busy && !wb_cyc_o && spur_en && $urandom_range(0, 3) == 0) begin
                wb_ack_i = 1'($urandom_range(0, 1));
                wb_err_i = !wb_ack_i;
            end
        end
    end

    // Response monitor: chooses rready, checks accepted responses and hold behaviour.
    bit          hold = 1'b0;
    logic [31:0] hold_d;
    logic        hold_e;
    resp_t       e;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) chk("resp_hold", 128'({obi_rvalid_o, obi_rdata_o, obi_err_o}),
                          128'({1'b1, hold_d, hold_e}));
            case (rr_mode)
                0: obi_rready_i = 1'b0;
                1: obi_rready_i = 1'b1;
                default: obi_rready_i = 1'($urandom_range(0, 1));
            endcase
            if (obi_rvalid_o && obi_rready_i) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL resp_unexpected: got rdata=%h err=%b, required no response",
                             obi_rdata_o, obi_err_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp", 128'({obi_rdata_o, obi_err_o}), 128'({e.data, e.err}));
                end
                hold = 1'b0;
            end else if (obi_rvalid_o) begin
                hold = 1'b1; hold_d = obi_rdata_o; hold_e = obi_err_o;
            end else hold = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        txn_t t;
        int   n;
        rst_n = 1'b0; obi_req_i = 1'b0; obi_we_i = 1'b0; obi_addr_i = 32'h0;
        obi_be_i = 4'h0; obi_wdata_i = 32'h0; obi_rready_i = 1'b0;
        #12;
        chk("reset_outputs", 128'({obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o, wb_cyc_o,
                                   wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o}), 128'h0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_reset_idle", 128'({obi_gnt_o, wb_cyc_o}), 128'h0);

        // Read with two wait states.
        t = mk(1'b0, 32'h100, 4'hF, 32'h0, 2, 0, 32'hDEADBEEF);
        push_txn(t, 1'b0); do_req(t);
        n = 0;
        while (!obi_rvalid_o && n < 50) begin @(negedge clk); n++; end
        chk("read_latency", 128'(n), 128'(3));
        @(negedge clk); #1;
        chk("read_cyc_len", 128'(last_cyc_len), 128'(3));

        // Zero-wait read: rvalid in the third cycle counting the request cycle.
        t = mk(1'b0, 32'h204, 4'h5, 32'h0, 0, 0, 32'hCAFEF00D);
        push_txn(t, 1'b0); do_req(t);
        n = 0;
        while (!obi_rvalid_o && n < 50) begin @(negedge clk); n++; end
        chk("zero_wait_latency", 128'(n), 128'(1));
        @(negedge clk); #1;

        // Partial write, zero wait.
        t = mk(1'b1, 32'h308, 4'b0011, 32'h1234ABCD, 0, 0, 32'h0);
        push_txn(t, 1'b0); do_req(t);
        repeat (3) @(negedge clk); #1;

        // Error precedence and plain error on a write.
        t = mk(1'b0, 32'h40C, 4'hF, 32'h0, 1, 2, 32'h55AA55AA);
        push_txn(t, 1'b0); do_req(t);
        t = mk(1'b1, 32'h410, 4'hC, 32'h87654321, 0, 1, 32'h0);
        push_txn(t, 1'b0); do_req(t);
        repeat (4) @(negedge clk); #1;

        // Back-pressure: two responses fill the FIFO, third request must wait.
        rr_mode = 0;
        t = mk(1'b0, 32'h500, 4'hF, 32'h0, 0, 0, 32'h11111111); push_txn(t, 1'b0); do_req(t);
        t = mk(1'b0, 32'h504, 4'hF, 32'h0, 0, 0, 32'h22222222); push_txn(t, 1'b0); do_req(t);
        t = mk(1'b0, 32'h508, 4'hF, 32'h0, 0, 0, 32'h33333333); push_txn(t, 1'b0);
        obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = t.addr; obi_be_i = t.be;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_gnt_blocked", 128'(obi_gnt_o), 128'(0));
            @(negedge clk); #1;
        end
        chk("bp_fifo_full_rvalid", 128'(obi_rvalid_o), 128'(1));
        rr_mode = 1;
        @(negedge clk); #1;
        chk("bp_gnt_before_pop", 128'(obi_gnt_o), 128'(0));
        @(negedge clk); #1;
        chk("bp_gnt_after_pop", 128'(obi_gnt_o), 128'(1));
        @(negedge clk); #1 obi_req_i = 1'b0;
        repeat (4) @(negedge clk); #1;

        // Reset in the middle of a transfer flushes a queued response.
        rr_mode = 0;
        t = mk(1'b0, 32'h600, 4'hF, 32'h0, 0, 0, 32'h66666666); push_txn(t, 1'b0); do_req(t);
        t = mk(1'b0, 32'h604, 4'hF, 32'h0, 10, 0, 32'h77777777); push_txn(t, 1'b1); do_req(t);
        @(negedge clk); #1;
        chk("pre_reset_busy", 128'({wb_cyc_o, obi_rvalid_o}), 128'(2'b11));
        rst_n = 1'b0;
        #1 chk("reset_mid_bus", 128'({wb_cyc_o, wb_stb_o, obi_rvalid_o}), 128'h0);
        exp_q.delete();
        @(negedge clk); #1 rst_n = 1'b1; rr_mode = 1;
        repeat (3) @(negedge clk); #1;
        chk("fifo_empty_after_reset", 128'({obi_rvalid_o, wb_cyc_o}), 128'h0);

        // Randomized traffic with random back-pressure and spurious idle acks.
        rr_mode = 2; spur_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 5);
            t = mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)),
                   $urandom, $urandom_range(0, 3), (k < 4) ? 0 : k - 3, $urandom);
            push_txn(t, 1'b0); do_req(t);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
        end
        spur_en = 1'b0; rr_mode = 1;

`ifdef OBI_WB_TIMEOUT_EN
        // Silent slave: watchdog aborts after TO cycles; late ack ignored.
        repeat (10) @(negedge clk); #1;
        t = mk(1'b1, 32'h700, 4'hF, 32'hA5A5A5A5, 0, 3, 32'h0); push_txn(t, 1'b0); do_req(t);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        #1 chk("timeout_cyc_len", 128'(last_cyc_len), 128'(TO));
        t = mk(1'b0, 32'h704, 4'hF, 32'h0, 1, 0, 32'hBEEF0001); push_txn(t, 1'b0); do_req(t);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("drain_exp", 128'(exp_q.size()), 128'(0));
        chk("drain_plan", 128'(plan_q.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
